// File: rtl/mseq_sync.sv
// Chip-level synchroniser for a 31-chip M-sequence: builds its reference period,
// correlates a sliding window against it, and acquires, confirms and tracks lock.
module mseq_sync #(
    parameter logic [4:0] POLY     = 5'b11101,
    parameter logic [4:0] SEED     = 5'b10101,
    parameter int         THRESH   = 29,
    parameter int         LOCK_CNT = 3,
    parameter int         MISS_MAX = 2
) (
    input  logic       CLK_50MHZ,
    input  logic       RST_N,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       ready,
    output logic       locked,
    output logic       sync_pulse,
    output logic [4:0] corr,
    output logic [4:0] phase
);

    typedef enum logic [1:0] {INIT, SEARCH, VERIFY, LOCKED} state_t;

    localparam int CW = 4;

    state_t          state;
    logic [4:0]      lfsr;
    logic [4:0]      step_cnt;
    logic [30:0]     ref_pat;
    logic [30:0]     win;
    logic            pend;
    logic [CW-1:0]   hit_cnt;
    logic [CW-1:0]   miss_cnt;

    logic            accept;
    logic [4:0]      agree;
    logic            hit;
    logic            aligned;
    logic [4:0]      phase_inc;
    logic [CW-1:0]   hit_nxt;
    logic [CW-1:0]   miss_nxt;
    logic            fb;

    // Evaluation happens one edge after a chip enters the window; at that edge
    // phase still carries the index of the evaluated chip.
    always_comb begin
        accept    = (state != INIT) && bit_valid;
        agree     = 5'd31 - 5'($countones(win ^ ref_pat));
        hit       = (agree >= 5'(THRESH));
        aligned   = (phase == 5'd0);
        phase_inc = (phase == 5'd30) ? 5'd0 : phase + 5'd1;
        hit_nxt   = (hit_cnt == CW'(LOCK_CNT)) ? hit_cnt : hit_cnt + 1'b1;
        miss_nxt  = (miss_cnt == CW'(MISS_MAX)) ? miss_cnt : miss_cnt + 1'b1;
        fb        = ^(lfsr & POLY);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state      <= INIT;
            lfsr       <= SEED;
            step_cnt   <= 5'd0;
            ref_pat    <= '0;
            win        <= '0;
            pend       <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            ready      <= 1'b0;
            locked     <= 1'b0;
            sync_pulse <= 1'b0;
            corr       <= 5'd0;
            phase      <= 5'd0;
        end else begin
            sync_pulse <= 1'b0;
            pend       <= accept;
            if (accept)
                win <= {win[29:0], bit_in};
            if (pend)
                corr <= agree;

            case (state)
                INIT: begin
                    ref_pat  <= {ref_pat[29:0], lfsr[0]};
                    lfsr     <= {fb, lfsr[4:1]};
                    step_cnt <= (step_cnt == 5'd30) ? step_cnt : step_cnt + 5'd1;
                    if (step_cnt == 5'd30) begin
                        state <= SEARCH;
                        ready <= 1'b1;
                    end
                end

                SEARCH: begin
                    phase <= 5'd0;
                    if (pend && hit) begin
                        state   <= VERIFY;
                        hit_cnt <= CW'(1);
                        phase   <= bit_valid ? 5'd1 : 5'd0;
                    end
                end

                VERIFY: begin
                    if (accept)
                        phase <= phase_inc;
                    if (pend && aligned) begin
                        if (hit) begin
                            sync_pulse <= 1'b1;
                            hit_cnt    <= hit_nxt;
                            if (hit_nxt == CW'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state   <= SEARCH;
                            phase   <= 5'd0;
                            hit_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    if (accept)
                        phase <= phase_inc;
                    if (pend && aligned) begin
                        if (hit) begin
                            sync_pulse <= 1'b1;
                            miss_cnt   <= '0;
                        end else begin
                            miss_cnt <= miss_nxt;
                            if (miss_nxt == CW'(MISS_MAX)) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                phase    <= 5'd0;
                                hit_cnt  <= '0;
                                miss_cnt <= '0;
                            end
                        end
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

endmodule
